nand_cmd_addr_tx: RTL

NAND command/address-phase transmitter: it consumes the page/block address and mode from the address generator and drives the NAND CLE/ALE/WE#/IO pins with the opcode and address-cycle sequence for read, program or erase. It returns a one-cycle `done` to the address generator, which closes the loop so the generator advances to the next page or block. It sits between the address generator and the NAND pad ring; the data-phase engines own the bus outside this block's active window.

---
 rtl/nand_pkg.sv | 34 +++
 rtl/nand_we_timer.sv | 31 +++
 rtl/nand_cmd_addr_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/nand_pkg.sv
// Shared constants for the NAND command/address-phase transmitter.
package nand_pkg;

  localparam int ROW_W = 17;

  localparam logic [7:0] OP_READ1  = 8'h00;
  localparam logic [7:0] OP_READ2  = 8'h30;
  localparam logic [7:0] OP_PROG   = 8'h80;
  localparam logic [7:0] OP_ERASE1 = 8'h60;
  localparam logic [7:0] OP_ERASE2 = 8'hD0;

  localparam logic [1:0] CON_NOP   = 2'b00;
  localparam logic [1:0] CON_READ  = 2'b01;
  localparam logic [1:0] CON_PROG  = 2'b10;
  localparam logic [1:0] CON_ERASE = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CMD1    = 3'd1;
  localparam state_t ST_ADDR    = 3'd2;
  localparam state_t ST_CMD2    = 3'd3;
  localparam state_t ST_WB      = 3'd4;
  localparam state_t ST_WAIT_RB = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  // Erase addresses a whole block, so the page field is forced to zero.
  function automatic logic [ROW_W-1:0] row_of(input logic [1:0]  con,
                                               input logic [10:0] blk,
                                               input logic [5:0]  pg);
    return {blk, (con == CON_ERASE) ? 6'd0 : pg};
  endfunction

endpackage

// File: rtl/nand_we_timer.sv
// Per-bus-cycle WE# timer: TWP clocks low phase, then TWH clocks high phase.
module nand_we_timer
  import nand_pkg::*;
#(
  parameter int unsigned TWP = 2,
  parameter int unsigned TWH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_we_phase,
  output logic o_cycle_end
);

  localparam int          CW   = $clog2(TWP + TWH + 1);
  localparam logic [CW-1:0] LOAD = CW'(TWP + TWH - 1);
  localparam logic [CW-1:0] THI  = CW'(TWH);

  logic [CW-1:0] r_cnt;

  // Down-counter reloads at terminal count so bus cycles run back-to-back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_cnt <= LOAD;
    else if (!i_run || r_cnt == '0)    r_cnt <= LOAD;
    else                               r_cnt <= r_cnt - 1'b1;
  end

  assign o_we_phase  = i_run && (r_cnt >= THI);
  assign o_cycle_end = i_run && (r_cnt == '0);

endmodule

// File: rtl/nand_cmd_addr_tx.sv
// NAND command/address-phase transmitter (read, program, erase).
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | waiting for add_vail with a non-zero mode
// CMD1       | first opcode bus cycle (cle=1)
// ADDR       | address bus cycles, counter 0..4 (0..2 erase)
// CMD2       | confirm opcode bus cycle (read/erase only)
// WB         | fixed TWB-clock wait before looking at R/B#
// WAIT_RB    | hold until synchronized R/B# reports ready
// DONE       | one-clock completion pulse
module nand_cmd_addr_tx
  import nand_pkg::*;
#(
  parameter int unsigned TWP = 2,
  parameter int unsigned TWH = 2,
  parameter int unsigned TWB = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_add_vail,
  input  logic [1:0]  i_con,
  input  logic [5:0]  i_page_address,
  input  logic [10:0] i_block_address,
  input  logic        i_rb_n,
  output logic [7:0]  o_io_out,
  output logic        o_io_oe,
  output logic        o_cle,
  output logic        o_ale,
  output logic        o_we_n,
  output logic        o_busy,
  output logic        o_done
);

  localparam int           WBW     = $clog2(TWB + 1);
  localparam logic [WBW-1:0] WB_LOAD = WBW'(TWB - 1);

  state_t             r_state;
  logic [1:0]         r_con;
  logic [ROW_W-1:0]   r_row;
  logic [2:0]         r_addr_cnt;
  logic [WBW-1:0]     r_wb_cnt;
  logic               r_rb_meta;
  logic               r_rb_sync;

  logic               w_run;
  logic               w_we_phase;
  logic               w_cycle_end;
  logic               w_accept;
  logic [2:0]         w_addr_last;
  logic [2:0]         w_addr_idx;
  logic [7:0]         w_addr_byte;

  assign w_run       = (r_state == ST_CMD1) || (r_state == ST_ADDR) || (r_state == ST_CMD2);
  assign w_accept    = (r_state == ST_IDLE) && i_add_vail && (i_con != CON_NOP);
  assign w_addr_last = (r_con == CON_ERASE) ? 3'd2 : 3'd4;
  // Erase skips the two column cycles, so its counter maps onto the row slots.
  assign w_addr_idx  = (r_con == CON_ERASE) ? (r_addr_cnt + 3'd2) : r_addr_cnt;

  nand_we_timer #(
    .TWP (TWP),
    .TWH (TWH)
  ) u_we_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_run       (w_run),
    .o_we_phase  (w_we_phase),
    .o_cycle_end (w_cycle_end)
  );

  // Two-flop synchronizer for the asynchronous R/B# pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rb_meta <= 1'b0;
      r_rb_sync <= 1'b0;
    end else begin
      r_rb_meta <= i_rb_n;
      r_rb_sync <= r_rb_meta;
    end
  end

  // Address byte select: C1, C2, R1, R2, R3.
  always_comb begin
    w_addr_byte = 8'h00;
    case (w_addr_idx)
      3'd2:    w_addr_byte = r_row[7:0];
      3'd3:    w_addr_byte = r_row[15:8];
      3'd4:    w_addr_byte = {7'b0, r_row[16]};
      default: w_addr_byte = 8'h00;
    endcase
  end

  // Sequencer: capture in IDLE, step bus cycles on timer terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_con      <= CON_NOP;
      r_row      <= '0;
      r_addr_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_con      <= i_con;
            r_row      <= row_of(i_con, i_block_address, i_page_address);
            r_addr_cnt <= '0;
            r_state    <= ST_CMD1;
          end
        end
        ST_CMD1: begin
          if (w_cycle_end) r_state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (w_cycle_end) begin
            if (r_addr_cnt == w_addr_last)
              r_state <= (r_con == CON_PROG) ? ST_DONE : ST_CMD2;
            else
              r_addr_cnt <= r_addr_cnt + 3'd1;
          end
        end
        ST_CMD2: begin
          if (w_cycle_end) begin
            r_state  <= ST_WB;
            r_wb_cnt <= WB_LOAD;
          end
        end
        ST_WB: begin
          if (r_wb_cnt == '0) r_state <= ST_WAIT_RB;
          else                r_wb_cnt <= r_wb_cnt - 1'b1;
        end
        ST_WAIT_RB: begin
          if (r_rb_sync) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pin drive decoded from state; bus-cycle values only change with the state.
  always_comb begin
    o_io_out = 8'h00;
    o_io_oe  = 1'b0;
    o_cle    = 1'b0;
    o_ale    = 1'b0;
    case (r_state)
      ST_CMD1: begin
        o_io_oe  = 1'b1;
        o_cle    = 1'b1;
        o_io_out = (r_con == CON_READ) ? OP_READ1 :
                   (r_con == CON_PROG) ? OP_PROG  : OP_ERASE1;
      end
      ST_ADDR: begin
        o_io_oe  = 1'b1;
        o_ale    = 1'b1;
        o_io_out = w_addr_byte;
      end
      ST_CMD2: begin
        o_io_oe  = 1'b1;
        o_cle    = 1'b1;
        o_io_out = (r_con == CON_ERASE) ? OP_ERASE2 : OP_READ2;
      end
      default: ;
    endcase
  end

  assign o_we_n = ~w_we_phase;
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_DONE);

endmodule
